// File: rtl/instr_encoder_loader.sv
// Packs LEGv8 instruction fields into 32-bit words and streams them into instruction memory.
// One registered write per accepted tuple (1 word / 2 cycles); oREADY holds the source off when busy or full.
`timescale 1ns/1ps
module instr_encoder_loader #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iCLEAR,
  input  logic              iVALID,
  output logic              oREADY,
  input  logic [2:0]        iFORMAT,
  input  logic [10:0]       iOPCODE,
  input  logic [4:0]        iRD,
  input  logic [4:0]        iRN,
  input  logic [4:0]        iRM,
  input  logic [5:0]        iSHAMT,
  input  logic [25:0]       iIMM,
  output logic              oIMEM_WE,
  output logic [ADDR_W-1:0] oIMEM_ADDR,
  output logic [31:0]       oIMEM_DATA,
  output logic [ADDR_W:0]   oCOUNT,
  output logic              oFULL,
  output logic [1:0]        oERR
);

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_WRITE = 1'b1;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  logic              state_q, state_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       data_q, data_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [1:0]        err_q, err_d;

  logic [31:0] word;
  logic        legal;
  logic        trunc;
  logic        accept;

  // Signed fields are truncated unless every dropped bit equals the kept sign bit.
  always_comb begin
    word  = 32'd0;
    legal = 1'b1;
    trunc = 1'b0;
    case (iFORMAT)
      3'd0: word = {iOPCODE, iRM, iSHAMT, iRN, iRD};
      3'd1: begin
        word  = {iOPCODE[10:1], iIMM[11:0], iRN, iRD};
        trunc = |iIMM[25:12];
      end
      3'd2: begin
        word  = {iOPCODE, iIMM[8:0], 2'b00, iRN, iRD};
        trunc = !((&iIMM[25:8]) || !(|iIMM[25:8]));
      end
      3'd3: begin
        word  = {iOPCODE[10:3], iIMM[18:0], iRD};
        trunc = !((&iIMM[25:18]) || !(|iIMM[25:18]));
      end
      3'd4: word = {iOPCODE[10:5], iIMM};
      default: legal = 1'b0;
    endcase
  end

  assign oFULL  = (count_q == DEPTH_C);
  assign oREADY = (state_q == ST_IDLE) && !oFULL && !iCLEAR && !iRST;
  assign accept = iVALID && oREADY;

  always_comb begin
    state_d = state_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    count_d = count_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (iCLEAR) begin
          count_d = '0;
          err_d   = 2'b00;
        end else if (accept) begin
          if (legal) begin
            data_d  = word;
            addr_d  = count_q[ADDR_W-1:0];
            we_d    = 1'b1;
            state_d = ST_WRITE;
            if (trunc) err_d[1] = 1'b1;
          end else begin
            err_d[0] = 1'b1;
          end
        end
      end
      default: begin
        // The strobe is already out; a clear only replaces the increment.
        state_d = ST_IDLE;
        if (iCLEAR) begin
          count_d = '0;
          err_d   = 2'b00;
        end else begin
          count_d = count_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= 32'd0;
      count_q <= '0;
      err_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  assign oIMEM_WE   = we_q;
  assign oIMEM_ADDR = addr_q;
  assign oIMEM_DATA = data_q;
  assign oCOUNT     = count_q;
  assign oERR       = err_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader (DEPTH=4); memory writes are checked against a scoreboard queue.
`timescale 1ns/1ps
module tb_instr_encoder_loader;

  localparam int AW  = 8;
  localparam int DEP = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clr = 1'b0;
  logic          vld = 1'b0;
  logic          rdy;
  logic [2:0]    fmt = '0;
  logic [10:0]   op  = '0;
  logic [4:0]    rd  = '0;
  logic [4:0]    rn  = '0;
  logic [4:0]    rm  = '0;
  logic [5:0]    sh  = '0;
  logic [25:0]   imm = '0;
  logic          we;
  logic [AW-1:0] addr;
  logic [31:0]   data;
  logic [AW:0]   cnt;
  logic          full;
  logic [1:0]    err;

  int            checks = 0;
  int            errors = 0;
  int            writes = 0;
  int            base_writes;
  int            k;
  logic [39:0]   sb[$];
  logic [39:0]   mon_e;
  logic [7:0]    exp_cnt = 8'd0;

  instr_encoder_loader #(.DEPTH(DEP), .ADDR_W(AW)) dut (
    .iCLK(clk), .iRST(rst), .iCLEAR(clr), .iVALID(vld), .oREADY(rdy),
    .iFORMAT(fmt), .iOPCODE(op), .iRD(rd), .iRN(rn), .iRM(rm), .iSHAMT(sh), .iIMM(imm),
    .oIMEM_WE(we), .oIMEM_ADDR(addr), .oIMEM_DATA(data),
    .oCOUNT(cnt), .oFULL(full), .oERR(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && we) begin
      writes++;
      check("write_expected", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        check("wr_addr", 64'(addr), 64'(mon_e[39:32]));
        check("wr_data", 64'(data), 64'(mon_e[31:0]));
      end
    end
  end

  task automatic set_fields(input logic [2:0] f, input logic [10:0] o, input logic [4:0] d,
                            input logic [4:0] n, input logic [4:0] m, input logic [5:0] s,
                            input logic [25:0] i);
    fmt = f; op = o; rd = d; rn = n; rm = m; sh = s; imm = i;
  endtask

  // Called just after a negedge with the DUT idle; returns just after a negedge with the DUT idle.
  task automatic send(input logic [2:0] f, input logic [10:0] o, input logic [4:0] d,
                      input logic [4:0] n, input logic [4:0] m, input logic [5:0] s,
                      input logic [25:0] i, input logic [31:0] exp_word, input bit legal);
    int w;
    set_fields(f, o, d, n, m, s, i);
    vld = 1'b1;
    w = 0;
    while (!rdy && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("ready_timeout", 64'(rdy), 64'd1);
    if (legal) sb.push_back({exp_cnt, exp_word});
    @(posedge clk);
    #1 vld = 1'b0;
    @(negedge clk);
    if (legal) begin
      @(negedge clk);
      exp_cnt++;
    end
    #1;
  endtask

  task automatic do_clear();
    clr = 1'b1;
    #1 check("ready_in_clear", 64'(rdy), 64'd0);
    @(posedge clk);
    #1 clr = 1'b0;
    exp_cnt = 8'd0;
    @(negedge clk);
    #1;
    check("clear_count", 64'(cnt), 64'd0);
    check("clear_err", 64'(err), 64'd0);
    check("clear_full", 64'(full), 64'd0);
  endtask

  initial begin
    #1;
    check("rst_we", 64'(we), 64'd0);
    check("rst_addr", 64'(addr), 64'd0);
    check("rst_data", 64'(data), 64'd0);
    check("rst_count", 64'(cnt), 64'd0);
    check("rst_full", 64'(full), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_ready", 64'(rdy), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1 check("ready_after_rst", 64'(rdy), 64'd1);

    send(3'd0, 11'b10001011000, 5'd3, 5'd1, 5'd2, 6'd0, 26'd0, 32'h8B020023, 1'b1);
    check("r_count", 64'(cnt), 64'd1);
    check("r_err", 64'(err), 64'd0);
    send(3'd1, 11'b10010001000, 5'd9, 5'd10, 5'd31, 6'h3F, 26'd4, 32'h91001149, 1'b1);
    check("i_err", 64'(err), 64'd0);
    send(3'd1, 11'b10010001000, 5'd9, 5'd10, 5'd0, 6'd0, 26'd4096, 32'h91000149, 1'b1);
    check("i_trunc_err", 64'(err), 64'd2);
    send(3'd3, 11'b10110100000, 5'd7, 5'd31, 5'd31, 6'h3F, 26'd3, 32'hB4000067, 1'b1);
    check("full_count", 64'(cnt), 64'd4);
    check("full_flag", 64'(full), 64'd1);
    check("full_ready", 64'(rdy), 64'd0);
    check("cb_err", 64'(err), 64'd2);

    // A tuple offered while full is held, not dropped, and lands after the clear.
    base_writes = writes;
    set_fields(3'd2, 11'b11111000010, 5'd2, 5'd5, 5'd0, 6'd0, 26'd8);
    vld = 1'b1;
    repeat (3) @(negedge clk);
    #1 check("held_no_write", 64'(writes - base_writes), 64'd0);
    clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
    exp_cnt = 8'd0;
    check("clear_idle_count", 64'(cnt), 64'd0);
    check("clear_idle_err", 64'(err), 64'd0);
    sb.push_back({8'd0, 32'hF84080A2});
    @(posedge clk);
    #1 vld = 1'b0;
    repeat (2) @(negedge clk);
    exp_cnt = 8'd1;
    #1 check("held_count", 64'(cnt), 64'd1);

    send(3'd4, 11'b00010100000, 5'd0, 5'd0, 5'd0, 6'd0, 26'h3FFFFFF, 32'h17FFFFFF, 1'b1);
    check("b_err", 64'(err), 64'd0);
    send(3'd2, 11'b11111000010, 5'd2, 5'd5, 5'd0, 6'd0, 26'h3FFFFF8, 32'hF85F80A2, 1'b1);
    check("d_neg_err", 64'(err), 64'd0);
    send(3'd2, 11'b11111000010, 5'd2, 5'd5, 5'd0, 6'd0, 26'h0000100, 32'hF85000A2, 1'b1);
    check("d_trunc_err", 64'(err), 64'd2);
    check("d_full", 64'(full), 64'd1);

    do_clear();
    base_writes = writes;
    send(3'd6, 11'h7FF, 5'd1, 5'd1, 5'd1, 6'd1, 26'd1, 32'd0, 1'b0);
    @(negedge clk);
    #1;
    check("illegal_err", 64'(err), 64'd1);
    check("illegal_count", 64'(cnt), 64'd0);
    check("illegal_no_write", 64'(writes - base_writes), 64'd0);

    do_clear();
    base_writes = writes;
    k = 0;
    vld = 1'b1;
    set_fields(3'd0, 11'b10001011000, 5'd0, 5'd1, 5'd2, 6'd0, 26'd0);
    for (int c = 0; c < 14; c++) begin
      if (rdy) begin
        rd = 5'(k);
        sb.push_back({8'(k), 32'h8B020020 | 32'(k)});
        k++;
      end
      @(negedge clk);
      #1;
    end
    vld = 1'b0;
    check("stream_writes", 64'(writes - base_writes), 64'd4);
    check("stream_accepts", 64'(k), 64'd4);
    check("stream_count", 64'(cnt), 64'd4);
    check("stream_full", 64'(full), 64'd1);
    check("stream_ready", 64'(rdy), 64'd0);

    do_clear();
    send(3'd0, 11'b10001011000, 5'd3, 5'd1, 5'd2, 6'd0, 26'd0, 32'h8B020023, 1'b1);
    check("after_clear_count", 64'(cnt), 64'd1);

    // Clear landing on the WRITE cycle: the write goes out, then the count resets.
    base_writes = writes;
    set_fields(3'd1, 11'b10010001000, 5'd9, 5'd10, 5'd0, 6'd0, 26'd4096);
    vld = 1'b1;
    sb.push_back({8'd1, 32'h91000149});
    @(posedge clk);
    #1 vld = 1'b0;
    check("wclr_we", 64'(we), 64'd1);
    check("wclr_err_set", 64'(err), 64'd2);
    clr = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1 clr = 1'b0;
    exp_cnt = 8'd0;
    check("wclr_writes", 64'(writes - base_writes), 64'd1);
    check("wclr_count", 64'(cnt), 64'd0);
    check("wclr_err", 64'(err), 64'd0);
    check("wclr_we_low", 64'(we), 64'd0);

    @(negedge clk);
    set_fields(3'd0, 11'b10001011000, 5'd3, 5'd1, 5'd2, 6'd0, 26'd0);
    vld = 1'b1;
    @(posedge clk);
    #1 vld = 1'b0;
    check("rstw_we", 64'(we), 64'd1);
    #1 rst = 1'b1;
    #1;
    check("rstw_we_drop", 64'(we), 64'd0);
    check("rstw_addr", 64'(addr), 64'd0);
    check("rstw_data", 64'(data), 64'd0);
    check("rstw_count", 64'(cnt), 64'd0);
    check("rstw_full", 64'(full), 64'd0);
    check("rstw_err", 64'(err), 64'd0);
    check("rstw_ready", 64'(rdy), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 check("rstw_ready_release", 64'(rdy), 64'd1);

    repeat (2) @(negedge clk);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
- Inverse of the unicycle opcode decoder. Accepts instruction fields (format, 11-bit opcode pattern, registers, shamt, immediate) over a valid/ready handshake.
- Packs the fields into 32-bit LEGv8 instruction words.
- Writes the words sequentially into instruction memory through a registered write port.
- Used by the testbench/boot path to load programs before the CPU is released from reset.

Parameters:
- DEPTH, 256, number of instruction words that can be loaded; must be ≤ 2^ADDR_W.
- ADDR_W, 8, width of the word address to instruction memory.

Ports:
- iCLK  in  1  clock; all state updates on rising edge.
- iRST  in  1  asynchronous, active-high reset.
- iCLEAR  in  1  synchronous; returns write pointer to 0 and clears oERR.
- iVALID  in  1  field tuple valid.
- oREADY  out  1  block can accept a tuple this cycle.
- iFORMAT  in  3  0=R, 1=I, 2=D, 3=CB, 4=B; 5-7 are illegal.
- iOPCODE  in  11  opcode pattern, left-aligned as in Parametros.v.
- iRD  in  5  Rd (or Rt for D/CB).
- iRN  in  5  Rn.
- iRM  in  5  Rm.
- iSHAMT  in  6  shift amount.
- iIMM  in  26  immediate / offset, two's complement where signed.
- oIMEM_WE  out  1  instruction-memory write strobe.
- oIMEM_ADDR  out  ADDR_W  word address.
- oIMEM_DATA  out  32  encoded instruction.
- oCOUNT  out  ADDR_W+1  words written since reset/clear.
- oFULL  out  1  oCOUNT == DEPTH.
- oERR  out  2  sticky; bit0 = illegal format, bit1 = immediate truncated.

Behaviour:
- Reset: iRST high forces IDLE. oIMEM_WE=0, oIMEM_ADDR=0, oIMEM_DATA=0, oCOUNT=0, oFULL=0, oERR=0. oREADY=0 while iRST is high; oREADY=1 in the first cycle after release.
- States: IDLE and WRITE.
- oREADY = (state==IDLE) && !oFULL && !iCLEAR.
- Accept: iVALID && oREADY at a rising edge.
  - Legal format: register the encoded word into oIMEM_DATA, drive oIMEM_ADDR = oCOUNT[ADDR_W-1:0], set oIMEM_WE=1, go to WRITE.
  - Illegal format (5-7): set oERR[0], no write, stay IDLE.
- WRITE lasts exactly one cycle (oIMEM_WE high for that cycle). Next edge: oIMEM_WE=0, oCOUNT+1, back to IDLE. Throughput is 1 word per 2 cycles.
- Full: when oCOUNT reaches DEPTH, oFULL=1 and oREADY=0. Tuples are held off, never dropped.
- Encoding (bit ranges of the output word):
  - R: [31:21]=iOPCODE, [20:16]=iRM, [15:10]=iSHAMT, [9:5]=iRN, [4:0]=iRD.
  - I: [31:22]=iOPCODE[10:1], [21:10]=iIMM[11:0], [9:5]=iRN, [4:0]=iRD.
  - D: [31:21]=iOPCODE, [20:12]=iIMM[8:0], [11:10]=00, [9:5]=iRN, [4:0]=iRD.
  - CB: [31:24]=iOPCODE[10:3], [23:5]=iIMM[18:0], [4:0]=iRD.
  - B: [31:26]=iOPCODE[10:5], [25:0]=iIMM.
- Truncation check: the word is still written with the truncated field, and oERR[1] is set, when:
  - I: iIMM[25:12] != 0 (immediate is unsigned);
  - D: iIMM[25:8] is not all-equal (not a sign extension);
  - CB: iIMM[25:18] is not all-equal;
  - B: never.
- iCLEAR:
  - In IDLE: oCOUNT=0, oFULL=0, oERR=0 on the next edge.
  - In WRITE: the in-flight write completes (strobe already high), then oCOUNT=0 instead of incrementing, and oERR clears.
- iRST mid-WRITE: strobe drops immediately; all outputs take their reset values.
- Unused field inputs for a format are ignored and never affect oERR.

Test Plan:
- Reset, then R ADD: OPCODE=11'b10001011000, RM=2, SHAMT=0, RN=1, RD=3 -> oIMEM_WE for one cycle, ADDR=0, DATA=0x8B020023, oCOUNT=1.
- I ADDI: OPCODE=11'b10010001000, IMM=4, RN=10, RD=9 -> DATA=0x91001149. Then IMM=4096 -> word written, oERR=2'b10.
- D LDUR: OPCODE=11'b11111000010, IMM=8, RN=5, RD=2 -> DATA=0xF84080A2. CB CBZ: OPCODE=11'b10110100000, IMM=3, RD=7 -> DATA=0xB4000067.
- B: OPCODE=11'b00010100000, IMM=26'h3FFFFFF -> DATA=0x17FFFFFF, oERR unchanged. FORMAT=6 -> no write, oERR[0]=1.
- DEPTH=4, iVALID held high -> exactly 4 writes at ADDR 0..3, oFULL=1, oREADY=0. Then iCLEAR -> oCOUNT=0, next write at ADDR 0.
- Assert iCLEAR during a WRITE cycle -> that write still occurs, oCOUNT=0 afterwards. Assert iRST during WRITE -> oIMEM_WE drops without waiting for a clock edge, all outputs at reset values.
